// File: rtl/demux_frame_sequencer_if.sv
// Serial frame input handshake plus the registered demux-side outputs of the sequencer.
// The master modport drives the stream; the slave modport is the sequencer.
interface demux_frame_sequencer_if #(
  parameter int SEL_W  = 3,
  parameter int FCNT_W = 8
);
  logic              in_valid;
  logic              in_data;
  logic              in_sof;
  logic              in_ready;
  logic              abort;
  logic              k;
  logic [SEL_W-1:0]  s;
  logic              k_vld;
  logic              frame_done;
  logic              err;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output in_valid, in_data, in_sof, abort,
    input  in_ready, k, s, k_vld, frame_done, err, frame_cnt
  );

  modport slave (
    input  in_valid, in_data, in_sof, abort,
    output in_ready, k, s, k_vld, frame_done, err, frame_cnt
  );
endinterface

// File: rtl/demux_frame_sequencer.sv
// Deserialises address+payload frames from a bit stream and steers each payload
// bit onto the addressed output of an 8-way demux through registered k/s.
module demux_frame_sequencer #(
  parameter int PAYLOAD_LEN = 8,
  parameter int SEL_W       = 3,
  parameter int FCNT_W      = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  demux_frame_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  localparam logic [7:0] LAST_BIT = 8'(PAYLOAD_LEN - 1);
  localparam logic [1:0] LAST_ADR = 2'(SEL_W - 1);

  state_t             state;
  logic [SEL_W-1:0]   addr;
  logic [SEL_W-1:0]   s_q;
  logic [1:0]         addr_cnt;
  logic [7:0]         bit_cnt;
  logic               k_q;
  logic               k_vld_q;
  logic               done_q;
  logic               err_q;
  logic               ready_q;
  logic [FCNT_W-1:0]  cnt_q;
  logic               accept;

  assign accept = bus.in_valid & ready_q;

  // A sof beat always restarts address collection, whatever frame was in flight;
  // abort overrides everything else on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      addr     <= '0;
      s_q      <= '0;
      addr_cnt <= '0;
      bit_cnt  <= '0;
      k_q      <= 1'b0;
      k_vld_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      ready_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      k_q     <= 1'b0;
      k_vld_q <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      if (bus.abort) begin
        state   <= IDLE;
        ready_q <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            ready_q <= 1'b1;
            if (accept && bus.in_sof) begin
              addr     <= {{(SEL_W-1){1'b0}}, bus.in_data};
              addr_cnt <= 2'd1;
              state    <= ADDR;
            end
          end
          ADDR, DATA: begin
            if (accept) begin
              if (bus.in_sof) begin
                err_q    <= 1'b1;
                addr     <= {{(SEL_W-1){1'b0}}, bus.in_data};
                addr_cnt <= 2'd1;
                state    <= ADDR;
              end else if (state == ADDR) begin
                addr     <= {addr[SEL_W-2:0], bus.in_data};
                addr_cnt <= addr_cnt + 2'd1;
                if (addr_cnt == LAST_ADR) begin
                  bit_cnt <= '0;
                  state   <= DATA;
                end
              end else begin
                k_q     <= bus.in_data;
                k_vld_q <= 1'b1;
                s_q     <= addr;
                bit_cnt <= bit_cnt + 8'd1;
                if (bit_cnt == LAST_BIT) begin
                  state   <= GAP;
                  ready_q <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= cnt_q + FCNT_W'(1);
                end
              end
            end
          end
          GAP: begin
            state   <= IDLE;
            ready_q <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = ready_q;
  assign bus.k          = k_q;
  assign bus.s          = s_q;
  assign bus.k_vld      = k_vld_q;
  assign bus.frame_done = done_q;
  assign bus.err        = err_q;
  assign bus.frame_cnt  = cnt_q;

endmodule
